// File: rtl/code_mem_arbiter.sv
// code_mem_arbiter
//   Shares the single code-memory port between instruction fetch (F) and the
//   data port (D, used for loads/stores into code space). F has fixed priority.
//   A starvation counter hands the port to D once D has been refused MAX_WAIT
//   arbitration rounds in a row. One access is in flight at a time. Memory read
//   data arrives one cycle after the address, so one access completes every
//   two cycles.
//
// Ports
//   iCLK, iRST                 clock, synchronous active-high reset
//   iFReq/iFAddr               fetch request and word address
//   oFGnt/oFValid/oFData       fetch grant, response pulse and read data
//   iDReq/iDWe/iDBe/iDAddr/iDWData   data request and its fields
//   oDGnt/oDValid/oDRData      data grant, response pulse, read data (0 on writes)
//   oMemRe/oMemWe/oMemBe/oMemAddr/oMemWData   code-memory request side
//   iMemRData                  code-memory read data (cycle after oMemRe)
module code_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CW       = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFReq,
    input  logic [31:0] iFAddr,
    output logic        oFGnt,
    output logic        oFValid,
    output logic [31:0] oFData,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [3:0]  iDBe,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    output logic        oDGnt,
    output logic        oDValid,
    output logic [31:0] oDRData,
    output logic        oMemRe,
    output logic        oMemWe,
    output logic [3:0]  oMemBe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic [31:0] iMemRData
);

    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        RSP
    } state_t;

    state_t        state;
    state_t        stateNext;

    // Registered copy of the granted request; drives the memory during ACC.
    logic          ownerD;
    logic          weR;
    logic [3:0]    beR;
    logic [31:0]   addrR;
    logic [31:0]   wdataR;
    logic [CW-1:0] waitCnt;

    logic          arb;
    logic          dWin;

    // Address and write data keep their last value outside ACC.
    assign oMemAddr  = addrR;
    assign oMemWData = wdataR;

    always_comb begin
        stateNext = IDLE;
        oFGnt     = 1'b0;
        oDGnt     = 1'b0;
        oFValid   = 1'b0;
        oDValid   = 1'b0;
        oFData    = '0;
        oDRData   = '0;
        oMemRe    = 1'b0;
        oMemWe    = 1'b0;
        oMemBe    = '0;

        // Grants are suppressed while reset is asserted: the edge would
        // discard them anyway and the requester must not see a phantom accept.
        arb  = (state != ACC) && !iRST;
        dWin = iDReq && (!iFReq || (waitCnt >= WAIT_LIMIT));

        case (state)
            ACC: begin
                oMemRe    = !weR;
                oMemWe    = weR;
                oMemBe    = beR;
                stateNext = RSP;
            end
            RSP: begin
                oFValid = !ownerD;
                oDValid = ownerD;
                oFData  = ownerD ? '0 : iMemRData;
                oDRData = (ownerD && !weR) ? iMemRData : '0;
            end
            default: ;
        endcase

        if (arb) begin
            oDGnt = dWin;
            oFGnt = iFReq && !dWin;
            if (oDGnt || oFGnt) begin
                stateNext = ACC;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            waitCnt <= '0;
            ownerD  <= 1'b0;
            weR     <= 1'b0;
            beR     <= '0;
            addrR   <= '0;
            wdataR  <= '0;
        end else begin
            state <= stateNext;

            if (oFGnt || oDGnt) begin
                ownerD <= oDGnt;
                weR    <= oDGnt && iDWe;
                beR    <= oDGnt ? iDBe : 4'hF;
                addrR  <= oDGnt ? iDAddr : iFAddr;
                if (oDGnt) begin
                    wdataR <= iDWData;
                end
            end

            if (arb) begin
                if (oDGnt || !iDReq) begin
                    waitCnt <= '0;
                end else if (waitCnt != CNT_MAX) begin
                    waitCnt <= waitCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_code_mem_arbiter.sv
// tb_code_mem_arbiter
//   Scoreboard bench for code_mem_arbiter. A behavioural code memory answers
//   the DUT's memory port; a separate reference memory predicts each response,
//   which is queued at grant time and compared when oFValid/oDValid pulses.
module tb_code_mem_arbiter;

    logic        iCLK;
    logic        iRST;
    logic        iFReq;
    logic [31:0] iFAddr;
    logic        oFGnt;
    logic        oFValid;
    logic [31:0] oFData;
    logic        iDReq;
    logic        iDWe;
    logic [3:0]  iDBe;
    logic [31:0] iDAddr;
    logic [31:0] iDWData;
    logic        oDGnt;
    logic        oDValid;
    logic [31:0] oDRData;
    logic        oMemRe;
    logic        oMemWe;
    logic [3:0]  oMemBe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;

    code_mem_arbiter #(.MAX_WAIT(4), .CW(4)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iFReq(iFReq), .iFAddr(iFAddr), .oFGnt(oFGnt), .oFValid(oFValid), .oFData(oFData),
        .iDReq(iDReq), .iDWe(iDWe), .iDBe(iDBe), .iDAddr(iDAddr), .iDWData(iDWData),
        .oDGnt(oDGnt), .oDValid(oDValid), .oDRData(oDRData),
        .oMemRe(oMemRe), .oMemWe(oMemWe), .oMemBe(oMemBe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .iMemRData(iMemRData)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        isD;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] memArr [logic [29:0]];
    logic [31:0] refArr [logic [29:0]];

    function automatic logic [31:0] initVal(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memArr.exists(a[31:2]) ? memArr[a[31:2]] : initVal(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refArr.exists(a[31:2]) ? refArr[a[31:2]] : initVal(a);
    endfunction

    function automatic void refWrite(input logic [31:0] a, input logic [31:0] wd,
                                     input logic [3:0] be);
        refArr[a[31:2]] = merge(refRead(a), wd, be);
    endfunction

    // Behavioural code memory; read data is junk unless a read was issued.
    always @(posedge iCLK) begin
        if (oMemRe === 1'b1) iMemRData <= memRead(oMemAddr);
        else                 iMemRData <= $urandom;
        if (oMemWe === 1'b1) memArr[oMemAddr[31:2]] = merge(memRead(oMemAddr), oMemWData, oMemBe);
    end

    // Response monitor: pops the scoreboard on every valid pulse.
    always @(negedge iCLK) begin
        exp_t e;
        nTests++;
        if (oFValid === 1'b1 && oDValid === 1'b1) begin
            nFail++;
            $display("FAIL both_valid: oFValid=%b oDValid=%b want at most one", oFValid, oDValid);
        end
        if (oFValid === 1'b1 || oDValid === 1'b1) begin
            nTests++;
            if (q.size() == 0) begin
                nFail++;
                $display("FAIL unexpected_valid: oFValid=%b oDValid=%b with nothing outstanding",
                         oFValid, oDValid);
            end else begin
                e = q.pop_front();
                if (e.isD !== oDValid) begin
                    nFail++;
                    $display("FAIL resp_owner: got oDValid=%b want %b", oDValid, e.isD);
                end else if (e.isD && oDRData !== e.data) begin
                    nFail++;
                    $display("FAIL d_data: got %h want %h", oDRData, e.data);
                end else if (!e.isD && oFData !== e.data) begin
                    nFail++;
                    $display("FAIL f_data: got %h want %h", oFData, e.data);
                end
            end
        end
        nTests++;
        if ((oFValid !== 1'b1 && oFData !== 32'h0) || (oDValid !== 1'b1 && oDRData !== 32'h0)) begin
            nFail++;
            $display("FAIL idle_data: oFData=%h oDRData=%h want 0 when not valid", oFData, oDRData);
        end
    end

    task automatic doAccess(input bit isD, input bit we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd, input string name);
        exp_t e;
        int   waited;
        @(posedge iCLK); #1;
        if (isD) begin
            iDReq = 1'b1; iDWe = we; iDBe = be; iDAddr = addr; iDWData = wd;
        end else begin
            iFReq = 1'b1; iFAddr = addr;
        end
        waited = 0;
        @(negedge iCLK);
        while (!(isD ? oDGnt : oFGnt) && waited < 20) begin
            @(negedge iCLK);
            waited++;
        end
        nTests++;
        if (waited != 0) begin
            nFail++;
            $display("FAIL %s grant_latency: got %0d cycles want 0", name, waited);
            iFReq = 1'b0; iDReq = 1'b0;
            return;
        end
        e.isD = isD;
        if (isD && we) begin
            e.data = 32'h0;
            refWrite(addr, wd, be);
        end else begin
            e.data = refRead(addr);
        end
        q.push_back(e);
        @(posedge iCLK); #1;
        iFReq = 1'b0; iDReq = 1'b0;
        @(negedge iCLK);
        nTests++;
        if (oMemRe !== !we || oMemWe !== we || oMemAddr !== addr ||
            oMemBe !== (isD ? be : 4'hF) || (we && oMemWData !== wd)) begin
            nFail++;
            $display("FAIL %s acc_cycle: re=%b we=%b be=%h addr=%h wd=%h want re=%b we=%b be=%h addr=%h wd=%h",
                     name, oMemRe, oMemWe, oMemBe, oMemAddr, oMemWData,
                     !we, we, isD ? be : 4'hF, addr, wd);
        end
        @(negedge iCLK);
        nTests++;
        if (oFValid !== !isD || oDValid !== isD || oMemWe !== 1'b0 || oMemRe !== 1'b0) begin
            nFail++;
            $display("FAIL %s rsp_cycle: fv=%b dv=%b re=%b we=%b want fv=%b dv=%b re=0 we=0",
                     name, oFValid, oDValid, oMemRe, oMemWe, !isD, isD);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        nTests++;
        if ({oFGnt, oDGnt, oFValid, oDValid, oMemRe, oMemWe} !== 6'b0 || oMemBe !== 4'h0 ||
            oMemAddr !== 32'h0 || oMemWData !== 32'h0) begin
            nFail++;
            $display("FAIL reset_outputs: gnt=%b%b valid=%b%b re=%b we=%b be=%h addr=%h wd=%h want all 0",
                     oFGnt, oDGnt, oFValid, oDValid, oMemRe, oMemWe, oMemBe, oMemAddr, oMemWData);
        end
        @(posedge iCLK); #1;
        iRST = 1'b0;
    endtask

    task automatic test_fetch();
        doAccess(1'b0, 1'b0, 4'hF, 32'h0040_0000, 32'h0, "f_read");
    endtask

    task automatic test_dwrite();
        doAccess(1'b1, 1'b1, 4'b0011, 32'h0040_0010, 32'hDEAD_BEEF, "d_write");
        doAccess(1'b1, 1'b0, 4'hF, 32'h0040_0010, 32'h0, "d_readback");
    endtask

    task automatic test_dread();
        doAccess(1'b1, 1'b0, 4'hF, 32'h8000_0180, 32'h0, "d_read_ktext");
    endtask

    task automatic test_back_to_back();
        int   cyc;
        int   nG;
        int   nV;
        int   gCyc[2];
        int   vCyc[2];
        exp_t e;
        @(posedge iCLK); #1;
        iFReq = 1'b1; iFAddr = 32'h0040_0000;
        cyc = 0; nG = 0; nV = 0;
        while (cyc < 12 && nV < 2) begin
            @(negedge iCLK);
            if (oFValid === 1'b1 && nV < 2) begin vCyc[nV] = cyc; nV++; end
            if (oFGnt === 1'b1 && nG < 2) begin
                gCyc[nG] = cyc;
                e.isD = 1'b0; e.data = refRead(iFAddr);
                q.push_back(e);
                nG++;
                @(posedge iCLK); #1;
                if (nG == 1) iFAddr = 32'h0040_0004;
                else         iFReq = 1'b0;
            end
            cyc++;
        end
        iFReq = 1'b0;
        nTests++;
        if (nG != 2 || gCyc[1] - gCyc[0] != 2) begin
            nFail++;
            $display("FAIL b2b_grants: got %0d grants spacing %0d want 2 grants spacing 2",
                     nG, nG == 2 ? gCyc[1] - gCyc[0] : -1);
        end
        nTests++;
        if (nV != 2 || vCyc[0] != gCyc[0] + 2 || vCyc[1] != gCyc[0] + 4) begin
            nFail++;
            $display("FAIL b2b_valid_timing: got %0d valids at +%0d/+%0d want 2 at +2/+4",
                     nV, nV > 0 ? vCyc[0] - gCyc[0] : -1, nV > 1 ? vCyc[1] - gCyc[0] : -1);
        end
    endtask

    task automatic test_starvation();
        int   k;
        int   cyc;
        bit   wantD;
        exp_t e;
        @(posedge iCLK); #1;
        iFReq = 1'b1; iFAddr = 32'h0040_0100;
        iDReq = 1'b1; iDWe = 1'b0; iDBe = 4'hF; iDAddr = 32'h0040_0200; iDWData = 32'h0;
        k = 0; cyc = 0;
        while (k < 6 && cyc < 60) begin
            @(negedge iCLK);
            cyc++;
            if (oFGnt === 1'b1 || oDGnt === 1'b1) begin
                wantD = (k == 4);
                nTests++;
                if (oDGnt !== wantD || oFGnt !== !wantD) begin
                    nFail++;
                    $display("FAIL starve_round%0d: fgnt=%b dgnt=%b want fgnt=%b dgnt=%b",
                             k, oFGnt, oDGnt, !wantD, wantD);
                end
                e.isD  = wantD;
                e.data = refRead(wantD ? iDAddr : iFAddr);
                q.push_back(e);
                k++;
                @(posedge iCLK); #1;
                if (k == 5) iDReq = 1'b0;
                if (k == 6) iFReq = 1'b0;
            end
        end
        iFReq = 1'b0; iDReq = 1'b0;
        nTests++;
        if (k != 6) begin
            nFail++;
            $display("FAIL starve_timeout: got %0d grants want 6", k);
        end
        repeat (3) @(posedge iCLK);
    endtask

    task automatic test_reset_in_acc();
        @(posedge iCLK); #1;
        iDReq = 1'b1; iDWe = 1'b1; iDBe = 4'hF; iDAddr = 32'h0040_0020; iDWData = 32'h1234_5678;
        @(negedge iCLK);
        nTests++;
        if (oDGnt !== 1'b1) begin
            nFail++;
            $display("FAIL rst_acc_grant: got %b want 1", oDGnt);
        end
        @(posedge iCLK); #1;
        iDReq = 1'b0; iRST = 1'b1;
        // The memory commits the write at the end of this ACC cycle.
        refWrite(32'h0040_0020, 32'h1234_5678, 4'hF);
        @(negedge iCLK);
        nTests++;
        if (oMemWe !== 1'b1) begin
            nFail++;
            $display("FAIL rst_acc_we: got %b want 1", oMemWe);
        end
        @(posedge iCLK); #1;
        iRST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge iCLK);
            nTests++;
            if (oDValid !== 1'b0 || oMemWe !== 1'b0 || oMemRe !== 1'b0 || oMemAddr !== 32'h0) begin
                nFail++;
                $display("FAIL rst_abandon%0d: dv=%b we=%b re=%b addr=%h want 0", i,
                         oDValid, oMemWe, oMemRe, oMemAddr);
            end
        end
        doAccess(1'b1, 1'b0, 4'hF, 32'h0040_0020, 32'h0, "post_rst_read");
        doAccess(1'b0, 1'b0, 4'hF, 32'h0040_0008, 32'h0, "post_rst_fetch");
    endtask

    initial begin
        iRST = 1'b1; iFReq = 1'b0; iFAddr = '0;
        iDReq = 1'b0; iDWe = 1'b0; iDBe = '0; iDAddr = '0; iDWData = '0;
        memArr[30'h0010_0000] = 32'h2008_0005;
        refArr[30'h0010_0000] = 32'h2008_0005;
        test_reset();
        test_fetch();
        test_dwrite();
        test_dread();
        test_back_to_back();
        test_starvation();
        test_reset_in_acc();
        repeat (4) @(negedge iCLK);
        nTests++;
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL drain: got %0d outstanding responses want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
